// File: rtl/pipe_skid_reg.sv
// Two-entry pipeline skid register between a producer and a consumer stage.
// in_ready depends only on registered state, so out_ready has no combinational path back upstream.
module pipe_skid_reg #(
    parameter int CTRL_W = 24,
    parameter int DATA_W = 32,
    parameter int DEST_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_alu,
    input  logic [DATA_W-1:0] in_pb,
    input  logic [DEST_W-1:0] in_dest,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_alu,
    output logic [DATA_W-1:0] out_pb,
    output logic [DEST_W-1:0] out_dest,
    output logic [1:0]        occupancy
);

    localparam int PAY_W = CTRL_W + 2 * DATA_W + DEST_W;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [PAY_W-1:0]   main_q, main_d;
    logic [PAY_W-1:0]   skid_q, skid_d;
    logic [PAY_W-1:0]   in_pay_s;
    logic               in_ready_q;
    logic               out_valid_q;
    logic [1:0]         occ_q;
    logic               accept_s;
    logic               consume_s;

    assign in_pay_s  = {in_ctrl, in_alu, in_pb, in_dest};
    assign accept_s  = in_valid & in_ready_q;
    assign consume_s = out_valid_q & out_ready;

    // Next-state and payload movement; vacated registers are zeroed so a bubble reads as a NOP.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept_s) begin
                        main_d  = in_pay_s;
                        state_d = ST_ONE;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (accept_s && consume_s) begin
                        main_d  = in_pay_s;
                        state_d = ST_ONE;
                    end else if (accept_s) begin
                        skid_d  = in_pay_s;
                        state_d = ST_TWO;
                    end else if (consume_s) begin
                        main_d  = '0;
                        state_d = ST_EMPTY;
                    end else begin
                        state_d = ST_ONE;
                    end
                end
                ST_TWO: begin
                    if (consume_s) begin
                        main_d  = skid_q;
                        skid_d  = '0;
                        state_d = ST_ONE;
                    end else begin
                        state_d = ST_TWO;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    main_d  = '0;
                    skid_d  = '0;
                end
            endcase
        end
    end

    // State, payload and handshake flags, all decoded from the next state so outputs come straight from flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            occ_q       <= 2'd0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= (state_d != ST_TWO);
            out_valid_q <= (state_d != ST_EMPTY);
            occ_q       <= state_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign occupancy = occ_q;
    assign out_ctrl  = main_q[DEST_W + 2 * DATA_W +: CTRL_W];
    assign out_alu   = main_q[DEST_W + DATA_W +: DATA_W];
    assign out_pb    = main_q[DEST_W +: DATA_W];
    assign out_dest  = main_q[DEST_W-1:0];

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: queue-based reference model checked every cycle, plus directed literal checks.
module tb_pipe_skid_reg;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [23:0] in_ctrl = 24'h0;
    logic [31:0] in_alu = 32'h0;
    logic [31:0] in_pb = 32'h0;
    logic [4:0]  in_dest = 5'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [23:0] out_ctrl;
    logic [31:0] out_alu;
    logic [31:0] out_pb;
    logic [4:0]  out_dest;
    logic [1:0]  occupancy;

    logic        w_in_valid = 1'b0;
    logic        w_in_ready;
    logic [7:0]  w_in_ctrl = 8'h0;
    logic [63:0] w_in_alu = 64'h0;
    logic [63:0] w_in_pb = 64'h0;
    logic [5:0]  w_in_dest = 6'h0;
    logic        w_out_valid;
    logic [7:0]  w_out_ctrl;
    logic [63:0] w_out_alu;
    logic [63:0] w_out_pb;
    logic [5:0]  w_out_dest;
    logic [1:0]  w_occupancy;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [23:0] ctrl;
        logic [31:0] alu;
        logic [31:0] pb;
        logic [4:0]  dest;
    } ent_t;

    ent_t mq[$];

    always #5 clk = ~clk;

    pipe_skid_reg u_dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(in_ctrl), .in_alu(in_alu), .in_pb(in_pb), .in_dest(in_dest),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ctrl(out_ctrl), .out_alu(out_alu), .out_pb(out_pb), .out_dest(out_dest),
        .occupancy(occupancy)
    );

    pipe_skid_reg #(.CTRL_W(8), .DATA_W(64), .DEST_W(6)) u_wide (
        .clk(clk), .reset(reset), .flush(1'b0),
        .in_valid(w_in_valid), .in_ready(w_in_ready),
        .in_ctrl(w_in_ctrl), .in_alu(w_in_alu), .in_pb(w_in_pb), .in_dest(w_in_dest),
        .out_valid(w_out_valid), .out_ready(1'b1),
        .out_ctrl(w_out_ctrl), .out_alu(w_out_alu), .out_pb(w_out_pb), .out_dest(w_out_dest),
        .occupancy(w_occupancy)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: a FIFO of at most two entries; pop on consume, then push on accept.
    always @(posedge clk or negedge reset) begin : model
        int  n;
        ent_t e;
        if (!reset) begin
            mq.delete();
        end else if (flush) begin
            mq.delete();
        end else begin
            n = mq.size();
            e = '{ctrl: in_ctrl, alu: in_alu, pb: in_pb, dest: in_dest};
            if (n > 0 && out_ready) void'(mq.pop_front());
            if (in_valid && n < 2) mq.push_back(e);
        end
    end

    // Compare DUT against the model once per cycle, mid-period.
    always @(negedge clk) begin : compare
        ent_t e;
        e = (mq.size() > 0) ? mq[0] : '0;
        check("m_out_valid", out_valid, mq.size() > 0);
        check("m_in_ready", in_ready, mq.size() < 2);
        check("m_occupancy", occupancy, mq.size());
        check("m_payload", {out_ctrl, out_alu, out_pb, out_dest}, e);
        check("m_occ_le2", occupancy <= 2'd2, 1'b1);
    end

    initial begin
        // Reset held with a pending input: everything stays empty.
        in_valid = 1'b1;
        in_ctrl  = 24'hABCDEF;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_out_valid", out_valid, 1'b0);
            check("rst_out_ctrl", out_ctrl, 24'h0);
            check("rst_occ", occupancy, 2'd0);
            check("rst_in_ready", in_ready, 1'b1);
        end
        reset = 1'b1;
        step();
        check("post_rst_accept", out_ctrl, 24'hABCDEF);
        check("post_rst_occ", occupancy, 2'd1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check("drain0_occ", occupancy, 2'd0);

        // Streaming with one-cycle latency.
        in_valid = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_alu = i;
            step();
            check("stream_alu", out_alu, i);
            check("stream_occ", occupancy, 2'd1);
        end
        in_valid = 1'b0;
        step();
        check("stream_drain", occupancy, 2'd0);

        // Stall and skid.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_alu    = 32'h11;
        step();
        in_alu = 32'h22;
        step();
        check("skid_occ", occupancy, 2'd2);
        check("skid_in_ready", in_ready, 1'b0);
        check("skid_alu", out_alu, 32'h11);
        in_valid = 1'b0;
        step();
        check("skid_alu_stable", out_alu, 32'h11);
        out_ready = 1'b1;
        step();
        check("skid_second", out_alu, 32'h22);
        check("skid_ready_back", in_ready, 1'b1);
        step();
        check("skid_empty", occupancy, 2'd0);
        check("skid_bubble", out_alu, 32'h0);

        // Flush with a same-cycle input.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_alu    = 32'h44;
        in_ctrl   = 24'h123456;
        step();
        step();
        check("fl_full", occupancy, 2'd2);
        flush  = 1'b1;
        in_alu = 32'h55;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl_occ", occupancy, 2'd0);
        check("fl_valid", out_valid, 1'b0);
        check("fl_ctrl", out_ctrl, 24'h0);
        check("fl_ready", in_ready, 1'b1);
        step();
        check("fl_absent", occupancy, 2'd0);

        // Asynchronous reset mid-operation.
        in_valid = 1'b1;
        in_alu   = 32'h66;
        step();
        step();
        in_valid = 1'b0;
        #1 reset = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 1'b0);
        check("mid_rst_occ", occupancy, 2'd0);
        check("mid_rst_alu", out_alu, 32'h0);
        check("mid_rst_ready", in_ready, 1'b1);
        reset = 1'b1;
        step();
        check("mid_rst_stays", occupancy, 2'd0);

        // Wide instance: bit-exact copy.
        w_in_valid = 1'b1;
        w_in_pb    = 64'hDEADBEEF_CAFEF00D;
        w_in_dest  = 6'h2A;
        w_in_ctrl  = 8'hA5;
        step();
        w_in_valid = 1'b0;
        check("wide_pb", w_out_pb, 64'hDEADBEEF_CAFEF00D);
        check("wide_dest", w_out_dest, 6'h2A);
        check("wide_ctrl", w_out_ctrl, 8'hA5);

        // Random handshake traffic with occasional flush.
        for (int i = 0; i < 10000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 99) == 0);
            in_ctrl   = $urandom;
            in_alu    = $urandom;
            in_pb     = $urandom;
            in_dest   = $urandom;
            step();
        end
        flush    = 1'b0;
        in_valid = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
